// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 character-LCD controller: autonomous power-up init, then byte writes turned into pin-level cycles.
// Latency: RS/DATA driven the cycle after acceptance, EN after T_SETUP_CYC more, ready again after setup+EN+hold+exec.
// Backpressure: o_wr_rdy is high only while idle; vld without rdy is ignored and nothing is queued.
`timescale 1ns/1ps
module lcd_hd44780_ctrl #(
    parameter int unsigned T_PWRUP_CYC = 375000,
    parameter int unsigned T_SETUP_CYC = 2,
    parameter int unsigned T_EN_CYC    = 12,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_CMD_CYC   = 1000,
    parameter int unsigned T_CLR_CYC   = 41000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_wr_vld,
    output logic       o_wr_rdy,
    input  logic       i_wr_rs,
    input  logic [7:0] i_wr_data,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on,
    output logic       o_init_done,
    output logic       o_busy
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned T_MAX = max2(max2(max2(T_PWRUP_CYC, T_SETUP_CYC), max2(T_EN_CYC, T_HOLD_CYC)),
                                         max2(T_CMD_CYC, T_CLR_CYC));
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    // Reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD      = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD     = CNT_W'(T_CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD     = CNT_W'(T_CLR_CYC - 1);

    // A zero-length phase would underflow the counter reload; refuse to elaborate.
    if (T_PWRUP_CYC == 0 || T_SETUP_CYC == 0 || T_EN_CYC == 0 ||
        T_HOLD_CYC == 0 || T_CMD_CYC == 0 || T_CLR_CYC == 0) begin : g_bad_timing
        $error("lcd_hd44780_ctrl: all timing parameters must be nonzero");
    end

    typedef enum logic [2:0] {
        S_PWRUP,
        S_LOAD,
        S_IDLE,
        S_SETUP,
        S_EN,
        S_HOLD,
        S_EXEC
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       init_idx;
    logic             is_clr;

    // 8-bit bus, 2 lines, display on / cursor off, clear, entry mode increment.
    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Clear and return-home commands need the long execution wait.
    assign is_clr = !o_lcd_rs && (o_lcd_data == 8'h01 || o_lcd_data == 8'h02 || o_lcd_data == 8'h03);

    assign o_lcd_rw = 1'b0;
    assign o_lcd_on = 1'b1;
    assign o_busy   = ~o_wr_rdy;

    // Sequencer: power-up wait, init ROM walk, then one pin-level write cycle per accepted request.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= S_PWRUP;
            cnt         <= '0;
            init_idx    <= '0;
            o_lcd_data  <= '0;
            o_lcd_rs    <= 1'b0;
            o_lcd_en    <= 1'b0;
            o_wr_rdy    <= 1'b0;
            o_init_done <= 1'b0;
        end else begin
            case (state)
                // Counter leaves reset at zero, so this one phase counts upward.
                S_PWRUP: begin
                    if (cnt == PWRUP_LAST) begin
                        cnt      <= '0;
                        init_idx <= '0;
                        state    <= S_LOAD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    o_lcd_data <= init_byte(init_idx);
                    o_lcd_rs   <= 1'b0;
                    cnt        <= SETUP_LD;
                    state      <= S_SETUP;
                end
                S_IDLE: begin
                    if (i_wr_vld && o_wr_rdy) begin
                        o_lcd_data <= i_wr_data;
                        o_lcd_rs   <= i_wr_rs;
                        o_wr_rdy   <= 1'b0;
                        cnt        <= SETUP_LD;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        o_lcd_en <= 1'b1;
                        cnt      <= EN_LD;
                        state    <= S_EN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_EN: begin
                    if (cnt == '0) begin
                        o_lcd_en <= 1'b0;
                        cnt      <= HOLD_LD;
                        state    <= S_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= is_clr ? CLR_LD : CMD_LD;
                        state <= S_EXEC;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        if (!o_init_done && init_idx != 2'd3) begin
                            init_idx <= init_idx + 2'd1;
                            state    <= S_LOAD;
                        end else begin
                            o_init_done <= 1'b1;
                            o_wr_rdy    <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_PWRUP;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Hardware HD44780 character-LCD controller for the DE2 16x2 panel.
- Receives byte writes (command or data) over a valid/ready handshake and generates the LCD pin-level protocol itself: setup, EN pulse, hold and execution wait.
- Drives the same pin set the board wrapper exports (LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON).
- Runs the power-up init sequence autonomously, so software no longer bit-bangs EN timing.

Parameters:
- T_PWRUP_CYC, 375000: power-up wait before init, in cycles (15 ms at 25 MHz).
- T_SETUP_CYC, 2: cycles RS/DATA are stable before EN rises.
- T_EN_CYC, 12: EN high width, in cycles.
- T_HOLD_CYC, 2: cycles RS/DATA are held after EN falls.
- T_CMD_CYC, 1000: execution wait for normal command/data (40 us).
- T_CLR_CYC, 41000: execution wait for clear/home commands (1.64 ms).

Ports:
- i_clk  in  1  core clock (25 MHz domain)
- i_rstn  in  1  asynchronous active-low reset
- i_wr_vld  in  1  write request valid
- o_wr_rdy  out  1  controller can accept a write
- i_wr_rs  in  1  0 = command, 1 = data
- i_wr_data  in  8  byte to write
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  LCD register select
- o_lcd_rw  out  1  LCD read/write, tied 0 (write only)
- o_lcd_en  out  1  LCD enable strobe
- o_lcd_on  out  1  LCD power, 1 after reset
- o_init_done  out  1  init sequence complete
- o_busy  out  1  transfer or wait in progress

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rstn is asynchronous, active-low.
- Reset values: o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=1, o_init_done=0, o_wr_rdy=0, o_busy=1. State = S_PWRUP, delay counter=0, init index=0.
- Reset asserted mid-transfer aborts immediately: EN drops in the same instant and everything returns to reset values. No partial init state is retained.
- States:
  - S_PWRUP: count T_PWRUP_CYC cycles, then go to S_LOAD with init index 0.
  - S_LOAD: latch init byte[index] with rs=0, then go to S_SETUP. Init ROM: 0x38, 0x0C, 0x01, 0x06.
  - S_IDLE: o_wr_rdy=1, o_busy=0. On i_wr_vld&o_wr_rdy, latch i_wr_rs/i_wr_data and go to S_SETUP.
  - S_SETUP: drive latched RS/DATA for T_SETUP_CYC cycles, EN=0.
  - S_EN: EN=1 for T_EN_CYC cycles.
  - S_HOLD: EN=0 with RS/DATA held for T_HOLD_CYC cycles.
  - S_EXEC: wait T_CLR_CYC if rs=0 and data is 0x01, 0x02 or 0x03; otherwise wait T_CMD_CYC. Exit: during init, if index<3 then index+1 and go to S_LOAD; if index==3, set o_init_done=1 and go to S_IDLE. Outside init, go to S_IDLE.
- Handshake:
  - o_wr_rdy is high only in S_IDLE and is a registered output.
  - Acceptance occurs on the cycle vld&rdy. i_wr_vld while not ready is ignored, and nothing is queued.
  - Request data is captured at acceptance. Later changes on i_wr_* have no effect on the transfer.
  - Producer must hold vld until it sees rdy.
- Timing for acceptance at cycle t:
  - RS/DATA valid from t+1.
  - EN high on cycles t+1+S to t+S+E, where S=T_SETUP_CYC and E=T_EN_CYC.
  - o_wr_rdy high again at t+1+S+E+H+X, where H=T_HOLD_CYC and X=exec wait. Back-to-back writes are therefore spaced exactly S+E+H+X+1 cycles.
- o_lcd_data/o_lcd_rs keep their last value in S_IDLE, so no glitch while EN=0.
- Counters: a single down-counter sized for the largest parameter (clog2 of max+1). Zero-valued parameters are illegal; an assertion checks this in simulation.
- o_busy = ~o_wr_rdy.
- Writes before o_init_done are never accepted.

Test Plan:
- Sim params: PWRUP=50, SETUP=2, EN=3, HOLD=2, CMD=10, CLR=20.
- Reset, then run: o_lcd_en stays 0 for 50 cycles. Exactly 4 EN pulses of 3 cycles each follow, carrying 0x38, 0x0C, 0x01, 0x06 with rs=0. The gap after 0x01 reflects CLR=20, the others CMD=10. o_init_done rises with o_wr_rdy.
- Accept data write rs=1, 0x41 at cycle t: RS=1/DATA=0x41 from t+1, EN high t+3..t+5, o_wr_rdy returns at t+18.
- Accept command 0x01: o_wr_rdy returns at t+28 (CLR path). Command 0x80: returns at t+18.
- Hold i_wr_vld high continuously with changing data: exactly one write per 18-cycle slot. Each EN pulse carries the byte present at its acceptance cycle, and no byte is lost or duplicated.
- Deassert i_rstn while EN=1 mid-write: o_lcd_en=0 asynchronously. After release, the full power-up and init sequence repeats and o_init_done=0 until it completes.
- Pulse i_wr_vld during S_PWRUP and init: no extra EN pulse, o_wr_rdy stays 0, o_lcd_rw is 0 throughout.
